restoring_divider: RTL



---
 rtl/restoring_divider.sv | 92 +++++++++
 1 files changed

// File: rtl/restoring_divider.sv
// restoring_divider: iterative restoring divider, one quotient bit per clock, val/rdy/ctl streaming handshake
module restoring_divider #(
    parameter int BITS     = 256,
    parameter int CTL_BITS = 8
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic [2*BITS-1:0]   i_dat_n,
    input  logic [BITS-1:0]     i_dat_d,
    input  logic                i_val,
    input  logic [CTL_BITS-1:0] i_ctl,
    output logic                o_rdy,
    output logic                o_val,
    output logic [CTL_BITS-1:0] o_ctl,
    output logic [2*BITS-1:0]   o_quo,
    output logic [BITS-1:0]     o_rem,
    output logic                o_div0,
    input  logic                i_rdy
);
    localparam int CNT_W = $clog2(2 * BITS) + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(2 * BITS - 1);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t            state;
    logic [2*BITS-1:0] q;
    logic [BITS-1:0]   r;
    logic [BITS-1:0]   d_r;
    logic [BITS-1:0]   r_nxt;
    logic [BITS:0]     shifted;
    logic [CNT_W-1:0]  cnt;
    logic              ge;

    assign o_rdy = state == IDLE;

    // trial subtraction; the remainder stays below d_r, so it is kept BITS wide and the shifted-in bit gives the extra headroom
    always_comb begin
        shifted = {r, q[2*BITS-1]};
        ge      = shifted >= {1'b0, d_r};
        r_nxt   = ge ? shifted[BITS-1:0] - d_r : shifted[BITS-1:0];
    end

    // control FSM with registered result outputs; divide-by-zero short-circuits straight to DONE
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state  <= IDLE;
            q      <= '0;
            r      <= '0;
            d_r    <= '0;
            cnt    <= '0;
            o_val  <= 1'b0;
            o_ctl  <= '0;
            o_quo  <= '0;
            o_rem  <= '0;
            o_div0 <= 1'b0;
        end else begin
            case (state)
                IDLE: if (i_val) begin
                    q     <= i_dat_n;
                    d_r   <= i_dat_d;
                    o_ctl <= i_ctl;
                    r     <= '0;
                    cnt   <= '0;
                    if (i_dat_d == '0) begin
                        state  <= DONE;
                        o_quo  <= '1;
                        o_rem  <= i_dat_n[BITS-1:0];
                        o_div0 <= 1'b1;
                        o_val  <= 1'b1;
                    end else begin
                        state  <= CALC;
                        o_div0 <= 1'b0;
                    end
                end
                CALC: begin
                    q   <= {q[2*BITS-2:0], ge};
                    r   <= r_nxt;
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == LAST) begin
                        state <= DONE;
                        o_val <= 1'b1;
                        o_quo <= {q[2*BITS-2:0], ge};
                        o_rem <= r_nxt;
                    end
                end
                DONE: if (i_rdy) begin
                    o_val <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
